shift_add_mult_seq: RTL and testbench

//   Sequential unsigned shift-and-add multiplier: FSM plus internal datapath (left-shift register, bit counter, accumulator).
//   One operand pair per start/done handshake; SIZE iterations per product (fewer with early termination).

---
 rtl/shift_add_mult_seq_if.sv | 28 ++
 rtl/shift_add_mult_seq.sv | 110 +++++++++++
 tb/tb_shift_add_mult_seq.sv | 207 ++++++++++++++++++++
 3 files changed

// File: rtl/shift_add_mult_seq_if.sv
// Operand/result bundle for the sequential shift-and-add multiplier.
// Handshake: the master raises iStart with iA/iB valid. The request is
// accepted on the first rising edge where the slave is idle (oBusy=0).
// While oBusy=1 any iStart is ignored, so requests are not queued.
// oDone is a one-cycle pulse that marks oResult as valid. oResult then
// holds that value until the next oDone pulse or a reset.
interface shift_add_mult_seq_if #(
  parameter int SIZE = 8
);
  logic                iStart;
  logic [SIZE-1:0]     iA;
  logic [SIZE-1:0]     iB;
  logic                oBusy;
  logic                oDone;
  logic [2*SIZE-1:0]   oResult;

  // The requester drives the operands and start, and observes status and result.
  modport master (
    output iStart, iA, iB,
    input  oBusy, oDone, oResult
  );

  // The multiplier samples the operands and drives status and result.
  modport slave (
    input  iStart, iA, iB,
    output oBusy, oDone, oResult
  );
endinterface

// File: rtl/shift_add_mult_seq.sv
// shift_add_mult_seq: sequential unsigned shift-and-add multiplier.
// Each cycle in RUN, the multiplicand shifts left and the multiplier shifts
// right. The multiplicand is added into the accumulator whenever the current
// low multiplier bit is 1. A product takes SIZE RUN cycles plus one DONE cycle.
// Optional macro EARLY_TERMINATION_EN: RUN also ends once the remaining
// multiplier bits are all zero. The latency then depends on the operand,
// but the product is unchanged.
module shift_add_mult_seq #(
  parameter int SIZE = 8
) (
  input  logic                 Clock,
  input  logic                 Reset,
  shift_add_mult_seq_if.slave  mul_if,
  output logic [1:0]           dbg_state_o
);

  localparam int CNT_W = $clog2(SIZE) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SIZE - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t              state_q;
  logic [2*SIZE-1:0]   ash_q;
  logic [SIZE-1:0]     b_q;
  logic [2*SIZE-1:0]   acc_q;
  logic [CNT_W-1:0]    cnt_q;
  logic                busy_q;
  logic                done_q;
  logic [2*SIZE-1:0]   result_q;

  logic [2*SIZE-1:0]   sum_d;
  logic [SIZE-1:0]     b_shift_d;
  logic                last_run_d;

  // Accumulator plus the current partial product; the width is 2*SIZE, so it cannot overflow.
  always_comb begin
    sum_d = acc_q;
    if (b_q[0]) begin
      sum_d = acc_q + ash_q;
    end
  end

  assign b_shift_d = b_q >> 1;

`ifdef EARLY_TERMINATION_EN
  // The last RUN cycle is either the SIZE-th cycle or the cycle that leaves no multiplier bits set.
  assign last_run_d = (cnt_q == CNT_LAST) || (b_shift_d == '0);
`else
  // The last RUN cycle is always the SIZE-th cycle.
  assign last_run_d = (cnt_q == CNT_LAST);
`endif

  // Control FSM and datapath; all outputs are registered.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q  <= ST_IDLE;
      ash_q    <= '0;
      b_q      <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      result_q <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (mul_if.iStart) begin
            ash_q   <= {{SIZE{1'b0}}, mul_if.iA};
            b_q     <= mul_if.iB;
            acc_q   <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= ST_RUN;
          end
        end
        ST_RUN: begin
          acc_q <= sum_d;
          ash_q <= ash_q << 1;
          b_q   <= b_shift_d;
          cnt_q <= cnt_q + 1'b1;
          if (last_run_d) begin
            result_q <= sum_d;
            done_q   <= 1'b1;
            state_q  <= ST_DONE;
          end
        end
        ST_DONE: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
        default: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign mul_if.oBusy   = busy_q;
  assign mul_if.oDone   = done_q;
  assign mul_if.oResult = result_q;
  assign dbg_state_o    = state_q;

endmodule

// File: tb/tb_shift_add_mult_seq.sv
// Directed testbench for shift_add_mult_seq with SIZE=8.
// "Cycle k" is the value that the k-th rising edge samples, counted from the accept edge (edge 0).
// The bench looks at outputs 1ns after each rising edge, so a value seen after edge j belongs to cycle j+1.
module tb_shift_add_mult_seq;

  localparam int SIZE = 8;
  localparam int W    = 2 * SIZE;

  logic       clk;
  logic       rst;
  logic [1:0] dbg_state;

  shift_add_mult_seq_if #(.SIZE(SIZE)) bus_if ();

  shift_add_mult_seq #(.SIZE(SIZE)) dut (
    .Clock       (clk),
    .Reset       (rst),
    .mul_if      (bus_if.slave),
    .dbg_state_o (dbg_state)
  );

  // Clock and reset.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  logic [W-1:0] exp_q[$];
  int tests_run    = 0;
  int tests_failed = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Expected number of RUN cycles for multiplier b.
  function automatic int run_cycles(input logic [SIZE-1:0] b);
`ifdef EARLY_TERMINATION_EN
    int m;
    m = 0;
    for (int i = 0; i < SIZE; i++) if (b[i]) m = i;
    return m + 1;
`else
    return SIZE;
`endif
  endfunction

  function automatic logic [W-1:0] ref_mul(input logic [SIZE-1:0] a, input logic [SIZE-1:0] b);
    logic [W-1:0] acc;
    acc = '0;
    for (int i = 0; i < SIZE; i++) if (b[i]) acc = acc + (W'(a) << i);
    return acc;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One operation. ign_mask bit j pulses iStart with junk operands before edge j.
  task automatic run_op(input string tag, input logic [SIZE-1:0] a, input logic [SIZE-1:0] b,
                        input logic [63:0] ign_mask);
    int           done_j;
    int           done_cnt;
    logic         busy_ok;
    logic [W-1:0] exp;
    logic [W-1:0] res_at_done;
    exp_q.push_back(ref_mul(a, b));
    bus_if.iStart = 1'b1;
    bus_if.iA     = a;
    bus_if.iB     = b;
    step();
    bus_if.iStart = 1'b0;
    bus_if.iA     = SIZE'($urandom_range(0, (1 << SIZE) - 1));
    bus_if.iB     = SIZE'($urandom_range(0, (1 << SIZE) - 1));
    busy_ok     = (bus_if.oBusy === 1'b1);
    done_j      = -1;
    done_cnt    = 0;
    res_at_done = '0;
    for (int j = 1; j <= 40; j++) begin
      if (ign_mask[j]) begin
        bus_if.iStart = 1'b1;
        bus_if.iA     = SIZE'($urandom_range(1, (1 << SIZE) - 1));
        bus_if.iB     = SIZE'($urandom_range(1, (1 << SIZE) - 1));
      end
      step();
      bus_if.iStart = 1'b0;
      if (bus_if.oBusy !== 1'b1) busy_ok = 1'b0;
      if (bus_if.oDone === 1'b1) begin
        done_cnt++;
        done_j      = j;
        res_at_done = bus_if.oResult;
        break;
      end
    end
    exp = exp_q.pop_front();
    check({tag, " done_cycle"}, 32'(done_j + 1), 32'(run_cycles(b) + 1));
    check({tag, " result"}, 32'(res_at_done), 32'(exp));
    check({tag, " busy_during"}, 32'(busy_ok), 32'd1);
    if (done_j >= 0 && done_j < 63 && ign_mask[done_j + 1]) begin
      bus_if.iStart = 1'b1;
      bus_if.iA     = SIZE'($urandom_range(1, (1 << SIZE) - 1));
      bus_if.iB     = SIZE'($urandom_range(1, (1 << SIZE) - 1));
    end
    step();
    bus_if.iStart = 1'b0;
    if (bus_if.oDone === 1'b1) done_cnt++;
    check({tag, " single_done"}, 32'(done_cnt), 32'd1);
    check({tag, " idle_busy"}, 32'(bus_if.oBusy), 32'd0);
    step();
    check({tag, " result_held"}, 32'(bus_if.oResult), 32'(exp));
  endtask

  initial begin
    int           acc_edges[$];
    int           done_seen;
    logic         prev_busy;
    logic         no_done;
    logic [W-1:0] exp;

    rst           = 1'b1;
    bus_if.iStart = 1'b0;
    bus_if.iA     = '0;
    bus_if.iB     = '0;
    step();
    step();
    rst = 1'b0;
    check("reset busy", 32'(bus_if.oBusy), 32'd0);
    check("reset done", 32'(bus_if.oDone), 32'd0);
    check("reset result", 32'(bus_if.oResult), 32'd0);
    check("reset state", 32'(dbg_state), 32'd0);

    run_op("13x11", 8'd13, 8'd11, 64'd0);
    run_op("255x255", 8'd255, 8'd255, 64'd0);
    run_op("0x200", 8'd0, 8'd200, 64'd0);
    run_op("200x0", 8'd200, 8'd0, 64'd0);
    run_op("6x7_ignored_starts", 8'd6, 8'd7, (64'd1 << 3) | (64'd1 << 9));
    run_op("7x3", 8'd7, 8'd3, 64'd0);
    run_op("5x0", 8'd5, 8'd0, 64'd0);
    run_op("1x128", 8'd1, 8'd128, 64'd0);
    for (int k = 0; k < 4; k++) begin
      run_op("rand", SIZE'($urandom_range(0, 255)), SIZE'($urandom_range(0, 255)), 64'd0);
    end

    // Reset asserted at cycle 4 of 100*3 aborts the product without a done pulse.
    bus_if.iStart = 1'b1;
    bus_if.iA     = 8'd100;
    bus_if.iB     = 8'd3;
    step();
    bus_if.iStart = 1'b0;
    no_done = 1'b1;
    for (int j = 1; j <= 3; j++) begin
      step();
      if (bus_if.oDone === 1'b1) no_done = 1'b0;
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("abort busy", 32'(bus_if.oBusy), 32'd0);
    check("abort result", 32'(bus_if.oResult), 32'd0);
    check("abort state", 32'(dbg_state), 32'd0);
    for (int j = 0; j < SIZE + 2; j++) begin
      step();
      if (bus_if.oDone !== 1'b0 || bus_if.oBusy !== 1'b0) no_done = 1'b0;
    end
    check("abort no_done", 32'(no_done), 32'd1);
    run_op("2x2_after_abort", 8'd2, 8'd2, 64'd0);

    // iStart held high: one accept per operation, each one cycle after the previous DONE.
    for (int k = 0; k < 3; k++) exp_q.push_back(ref_mul(8'd9, 8'd9));
    bus_if.iA     = 8'd9;
    bus_if.iB     = 8'd9;
    bus_if.iStart = 1'b1;
    prev_busy     = 1'b0;
    done_seen     = 0;
    for (int e = 0; e < 3 * (run_cycles(8'd9) + 2); e++) begin
      step();
      if (bus_if.oBusy === 1'b1 && !prev_busy) acc_edges.push_back(e);
      prev_busy = bus_if.oBusy;
      if (bus_if.oDone === 1'b1) begin
        done_seen++;
        if (exp_q.size() > 0) begin
          exp = exp_q.pop_front();
          check("b2b result", 32'(bus_if.oResult), 32'(exp));
        end
      end
    end
    bus_if.iStart = 1'b0;
    check("b2b done_count", 32'(done_seen), 32'd3);
    check("b2b accept_count", 32'(acc_edges.size()), 32'd3);
    for (int k = 0; k < 3 && k < acc_edges.size(); k++) begin
      check("b2b accept_cycle", 32'(acc_edges[k]), 32'(k * (run_cycles(8'd9) + 2)));
    end
    step();
    step();
    check("b2b final_idle", 32'(bus_if.oBusy), 32'd0);
    check("scoreboard empty", 32'(exp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
